nvm_ctrl: RTL and testbench

- Command-driven initiator for the single-port word-addressed NVM array. Drives its `we`/`addr`/`wd` inputs and samples its combinational `rd` output.
- Accepts read, word-program, page-erase and unlock commands from the core/debug side over a valid/ready handshake.
- Sequences the memory access, enforces a one-shot write-unlock key, and returns a single-cycle response.
- Sits between the system bus bridge and the NVM array instance.

---
 rtl/nvm_ctrl.sv | 154 +++++++++++++++
 tb/tb_nvm_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nvm_ctrl.sv
// Command sequencer for the word-addressed NVM array: read, program and page erase,
// with a one-shot unlock key that gates every write.
module nvm_ctrl #(
  parameter int                         MEM_ADDR_WIDTH = 32,
  parameter int                         MEM_DATA_WIDTH = 32,
  parameter int                         PAGE_WORDS     = 16,
  parameter int                         WR_CYCLES      = 4,
  parameter logic [MEM_DATA_WIDTH-1:0]  ERASE_VAL      = '1,
  parameter logic [MEM_DATA_WIDTH-1:0]  UNLOCK_KEY     = MEM_DATA_WIDTH'(32'hA5C3_5A3C)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [MEM_ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [MEM_DATA_WIDTH-1:0]  cmd_wdata,
  output logic                       rsp_valid,
  output logic [MEM_DATA_WIDTH-1:0]  rsp_rdata,
  output logic                       rsp_err,
  output logic                       busy,
  output logic                       unlocked,
  output logic                       mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [MEM_DATA_WIDTH-1:0]  mem_wd,
  input  logic [MEM_DATA_WIDTH-1:0]  mem_rd
);

  localparam int PW = $clog2(PAGE_WORDS);
  localparam int CW = $clog2(WR_CYCLES + 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_CYCLES - 1);
  localparam logic [PW-1:0] IDX_LAST = '1;

  typedef enum logic [2:0] {IDLE, READ, PROG, ERASE, UNLK, RESP} state_t;

  state_t                         state;
  logic [CW-1:0]                  wr_cnt;
  logic [PW-1:0]                  idx;
  logic [MEM_ADDR_WIDTH-PW-1:0]   cap_page;
  logic [MEM_DATA_WIDTH-1:0]      cap_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      unlocked  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
      wr_cnt    <= '0;
      idx       <= '0;
      cap_page  <= '0;
      cap_data  <= '0;
    end else begin
      // Response fields are only non-zero during the single RESP cycle.
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            cap_page  <= cmd_addr[MEM_ADDR_WIDTH-1:PW];
            cap_data  <= cmd_wdata;
            wr_cnt    <= '0;
            idx       <= '0;
            case (cmd_op)
              2'b00: begin
                state    <= READ;
                mem_addr <= cmd_addr;
              end
              2'b01: begin
                if (unlocked) begin
                  state    <= PROG;
                  mem_addr <= cmd_addr;
                  mem_wd   <= cmd_wdata;
                  mem_we   <= (WR_LAST == '0);
                end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                end
              end
              2'b10: begin
                if (unlocked) begin
                  state    <= ERASE;
                  mem_addr <= {cmd_addr[MEM_ADDR_WIDTH-1:PW], PW'(0)};
                  mem_wd   <= ERASE_VAL;
                  mem_we   <= 1'b1;
                end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                end
              end
              2'b11: state <= UNLK;
            endcase
          end
        end
        READ: begin
          rsp_rdata <= mem_rd;
          rsp_valid <= 1'b1;
          mem_addr  <= '0;
          state     <= RESP;
        end
        PROG: begin
          if (wr_cnt == WR_LAST) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wd    <= '0;
            unlocked  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wr_cnt <= wr_cnt + CW'(1);
            mem_we <= (wr_cnt + CW'(1) == WR_LAST);
          end
        end
        ERASE: begin
          // The index alone advances, so the address stays inside the captured page.
          if (idx == IDX_LAST) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wd    <= '0;
            unlocked  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            idx      <= idx + PW'(1);
            mem_addr <= {cap_page, idx + PW'(1)};
          end
        end
        UNLK: begin
          unlocked  <= (cap_data == UNLOCK_KEY);
          rsp_err   <= (cap_data != UNLOCK_KEY);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_ctrl.sv
// Scoreboard bench for nvm_ctrl: an array model drives mem_rd, a command-level reference
// model predicts responses and memory writes, and a monitor compares them.
module tb_nvm_ctrl;

  localparam logic [31:0] KEY     = 32'hA5C3_5A3C;
  localparam logic [31:0] ERASE_V = 32'hFFFF_FFFF;
  localparam int          WRC     = 4;
  localparam int          PAGE    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, busy, unlocked, mem_we;
  logic [31:0] rsp_rdata, mem_addr, mem_wd, mem_rd;

  nvm_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .unlocked(unlocked), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; logic unl; int cyc; } rsp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // NVM array stand-in: synchronous write, combinational read.
  logic [31:0] nvm [logic [31:0]];
  int          wr_tick = 0;
  always @(posedge clk) begin
    cyc++;
    if (mem_we) begin
      nvm[mem_addr] = mem_wd;
      wr_tick++;
    end
  end
  always @(mem_addr or wr_tick)
    mem_rd = nvm.exists(mem_addr) ? nvm[mem_addr] : init_val(mem_addr);

  // Reference model state.
  logic [31:0] ref_mem [logic [31:0]];
  logic        ref_unl = 1'b0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares every write and every response against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_vs_busy", {31'd0, cmd_ready}, {31'd0, ~busy});
      if (mem_we) begin
        if (wq.size() == 0) chk("unexpected_write_addr", mem_addr, 32'hxxxx_xxxx);
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("write_addr", mem_addr, w.addr);
          chk("write_data", mem_wd, w.data);
          chk("write_cycle", cyc, w.cyc);
        end
      end
      if (rsp_valid) begin
        if (rq.size() == 0) chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        else begin
          rsp_t r;
          r = rq.pop_front();
          chk("rsp_rdata", rsp_rdata, r.rdata);
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
          chk("unlocked_at_rsp", {31'd0, unlocked}, {31'd0, r.unl});
          if (r.cyc >= 0) chk("rsp_latency", cyc, r.cyc);
        end
      end else if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
        chk("rsp_idle_zero", {rsp_rdata[30:0], rsp_err}, 32'd0);
      end
    end
  end

  // Issue one command and record the expected outcome. abort_at >= 0 marks an erase
  // that will be cut short by reset after that many words.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       input int abort_at = -1);
    rsp_t r;
    int   n = 0;
    int   acc;
    logic [31:0] base;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", {31'd0, cmd_ready}, 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    @(posedge clk);
    #1;
    acc = cyc;
    // Scramble the inputs while the command runs; the captured command must not change.
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    r.rdata = 32'd0; r.err = 1'b0; r.cyc = -1;
    case (op)
      2'd0: begin r.rdata = ref_rd(a); r.cyc = acc + 1; end
      2'd1: begin
        if (ref_unl) begin
          wq.push_back('{a, d, acc + WRC - 1});
          ref_mem[a] = d;
          ref_unl = 1'b0;
          r.cyc = acc + WRC;
        end else r.err = 1'b1;
      end
      2'd2: begin
        if (ref_unl) begin
          base = a & ~32'(PAGE - 1);
          for (int i = 0; i < PAGE; i++) begin
            if (abort_at < 0 || i < abort_at) begin
              wq.push_back('{base + 32'(i), ERASE_V, acc + i});
              ref_mem[base + 32'(i)] = ERASE_V;
            end
          end
          ref_unl = 1'b0;
          r.cyc = acc + PAGE;
        end else r.err = 1'b1;
      end
      default: begin
        ref_unl = (d == KEY);
        r.err = (d != KEY);
        r.cyc = acc + 1;
      end
    endcase
    r.unl = ref_unl;
    if (abort_at < 0) rq.push_back(r);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0 || !cmd_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_queue_drained", rq.size(), 0);
    chk("write_queue_drained", wq.size(), 0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_unlocked", {31'd0, unlocked}, 32'd0);
    chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'd0);
    chk("reset_mem_wd", mem_wd, 32'd0);
    chk("reset_rsp", {rsp_rdata[30:0], rsp_valid | rsp_err}, 32'd0);
    #2 rst = 1'b0;

    // Unlock then program, then a locked program, then read back.
    issue(2'd3, 32'd0, KEY);
    issue(2'd1, 32'h10, 32'hDEAD_BEEF);
    drain();
    chk("unlocked_after_prog", {31'd0, unlocked}, 32'd0);
    issue(2'd1, 32'h10, 32'h1234_5678);
    issue(2'd0, 32'h10, 32'd0);
    // Unlock survives a read and can be refreshed.
    issue(2'd3, 32'd0, KEY);
    issue(2'd0, 32'h30, 32'd0);
    issue(2'd3, 32'd0, KEY);
    issue(2'd2, 32'h2B, 32'd0);
    issue(2'd0, 32'h2B, 32'd0);
    issue(2'd0, 32'h30, 32'd0);
    issue(2'd0, 32'h1F, 32'd0);
    // Last page of the address space.
    issue(2'd3, 32'd0, KEY);
    issue(2'd2, 32'hFFFF_FFFF, 32'd0);
    issue(2'd0, 32'hFFFF_FFF0, 32'd0);
    issue(2'd0, 32'h0, 32'd0);
    // Wrong key, then a locked erase.
    issue(2'd3, 32'd0, 32'd0);
    issue(2'd2, 32'h40, 32'd0);
    drain();
    chk("unlocked_after_bad_key", {31'd0, unlocked}, 32'd0);

    // Reset during erase index 5 of page 0x40.
    issue(2'd3, 32'd0, KEY);
    issue(2'd2, 32'h47, 32'd0, 5);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_we_before", {31'd0, mem_we}, 32'd1);
    chk("abort_addr_before", mem_addr, 32'h45);
    rst = 1'b1;
    #1;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_unlocked", {31'd0, unlocked}, 32'd0);
    ref_unl = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    chk("abort_writes_seen", wq.size(), 0);
    for (int i = 0; i < PAGE; i++) issue(2'd0, 32'h40 + 32'(i), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 120; k++) begin
      logic [1:0]  op;
      logic [31:0] a, d;
      op = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63)))
                                       : 32'($urandom_range(0, 127));
      d  = $urandom;
      if (op == 2'd3 && $urandom_range(0, 1) == 1) d = KEY;
      if ((op == 2'd1 || op == 2'd2) && $urandom_range(0, 2) != 0) issue(2'd3, 32'd0, KEY);
      issue(op, a, d);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
